// File: rtl/bp_be_sys_event_sched.sv
// ---------------------------------------------------------------------------
// bp_be_sys_event_sched
//
// Schedules system events into the CSR unit: PTW page faults, committed
// exceptions and interrupts. Faults and exceptions each sit in a one-entry
// buffer and are issued by fixed priority (fault > exception > interrupt)
// through a single registered issue slot. Interrupts are only issued after a
// drain sequence in which dispatch is held off until the mem and long pipes
// are idle and no commit is in flight for drain_cycles_p consecutive cycles.
//
// Optional feature: define BP_SYS_EVT_PERF_EN to add the performance
// counters perf_irq_cnt_o (interrupt transfers) and perf_drain_cyc_o
// (cycles spent draining). Without the macro those ports do not exist.
//
// Ports
//   clk_i, reset_n_i            clock (rising edge), async active-low reset
//   ptw_fault_v_i/ready_o       PTW fault handshake, pc/vaddr alongside
//   commit_exc_v_i, commit_pc_i exception pulse from commit (never stalled)
//   commit_v_i                  an instruction commits this cycle
//   irq_pending_i               enabled interrupt pending in the CSR unit
//   pipe_mem_ready_i            mem pipe idle
//   pipe_long_ready_i           long pipe idle
//   flush_i                     pipeline flush
//   hold_dispatch_o             stall dispatch while draining / issuing irq
//   evt_v_o/type_o/pc_o/vaddr_o registered event to CSR, held until ready
//   evt_ready_i                 CSR accepts the event
//   irq_timeout_o               one-cycle pulse when a drain runs too long
// ---------------------------------------------------------------------------
module bp_be_sys_event_sched #(
    parameter int vaddr_width_p  = 39,
    parameter int drain_cycles_p = 2,
    parameter int irq_timeout_p  = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     ptw_fault_v_i,
    output logic                     ptw_fault_ready_o,
    input  logic [vaddr_width_p-1:0] ptw_fault_pc_i,
    input  logic [vaddr_width_p-1:0] ptw_fault_vaddr_i,

    input  logic                     commit_exc_v_i,
    input  logic [vaddr_width_p-1:0] commit_pc_i,
    input  logic                     commit_v_i,

    input  logic                     irq_pending_i,
    input  logic                     pipe_mem_ready_i,
    input  logic                     pipe_long_ready_i,
    input  logic                     flush_i,
    output logic                     hold_dispatch_o,

    output logic                     evt_v_o,
    output logic [1:0]               evt_type_o,
    output logic [vaddr_width_p-1:0] evt_pc_o,
    output logic [vaddr_width_p-1:0] evt_vaddr_o,
    input  logic                     evt_ready_i,

    output logic                     irq_timeout_o
`ifdef BP_SYS_EVT_PERF_EN
    ,
    output logic [31:0]              perf_irq_cnt_o,
    output logic [31:0]              perf_drain_cyc_o
`endif
);

    localparam int idle_cnt_w_lp = $clog2(drain_cycles_p + 1);
    localparam int wait_cnt_w_lp = $clog2(irq_timeout_p + 1);

    localparam logic [idle_cnt_w_lp-1:0] idle_last_lp = idle_cnt_w_lp'(drain_cycles_p - 1);
    localparam logic [idle_cnt_w_lp-1:0] idle_max_lp  = idle_cnt_w_lp'(drain_cycles_p);
    localparam logic [wait_cnt_w_lp-1:0] wait_last_lp = wait_cnt_w_lp'(irq_timeout_p - 1);
    localparam logic [wait_cnt_w_lp-1:0] wait_max_lp  = wait_cnt_w_lp'(irq_timeout_p);

    localparam logic [1:0] evt_fault_lp = 2'd0;
    localparam logic [1:0] evt_exc_lp   = 2'd1;
    localparam logic [1:0] evt_irq_lp   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_IRQ_ISSUE = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [idle_cnt_w_lp-1:0]   idle_cnt_q, idle_cnt_d;
    logic [wait_cnt_w_lp-1:0]   wait_cnt_q, wait_cnt_d;
    logic                       irq_timeout_q, irq_timeout_d;

    logic                       fault_v_q, fault_v_d;
    logic [vaddr_width_p-1:0]   fault_pc_q, fault_pc_d;
    logic [vaddr_width_p-1:0]   fault_vaddr_q, fault_vaddr_d;

    logic                       exc_v_q, exc_v_d;
    logic [vaddr_width_p-1:0]   exc_pc_q, exc_pc_d;

    logic                       evt_v_q, evt_v_d;
    logic [1:0]                 evt_type_q, evt_type_d;
    logic [vaddr_width_p-1:0]   evt_pc_q, evt_pc_d;
    logic [vaddr_width_p-1:0]   evt_vaddr_q, evt_vaddr_d;

    logic fault_in;     // fault accepted into the buffer this cycle
    logic evt_xfer;     // CSR takes the current event
    logic load_en;      // issue slot can take a new event at this edge
    logic exc_avail;    // buffered exception survives this cycle's flush
    logic pipes_idle;
    logic irq_launch;   // drain completed; interrupt enters the issue slot
    logic fault_take;
    logic exc_take;

    assign fault_in   = ptw_fault_v_i & ~fault_v_q;
    assign evt_xfer   = evt_v_q & evt_ready_i;
    assign load_en    = ~evt_v_q | evt_ready_i;
    assign exc_avail  = exc_v_q & ~flush_i;
    assign pipes_idle = pipe_mem_ready_i & pipe_long_ready_i & ~commit_v_i;

    // Interrupt drain FSM
    always_comb begin
        state_d       = state_q;
        idle_cnt_d    = idle_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        irq_timeout_d = 1'b0;
        irq_launch    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (irq_pending_i & ~fault_v_q & ~exc_v_q & ~evt_v_q) begin
                    state_d    = ST_DRAIN;
                    idle_cnt_d = '0;
                    wait_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                // Any fault/exception activity (new or already buffered)
                // aborts the drain so that event is issued first.
                if (~irq_pending_i | flush_i | fault_in | commit_exc_v_i
                    | fault_v_q | exc_v_q) begin
                    state_d = ST_IDLE;
                end else if (pipes_idle && (idle_cnt_q == idle_last_lp) && load_en) begin
                    state_d    = ST_IRQ_ISSUE;
                    irq_launch = 1'b1;
                end else begin
                    if (!pipes_idle) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q != idle_max_lp) begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                    // Saturating watchdog; the pulse fires on the step that
                    // reaches the limit, so it happens exactly once per drain.
                    if (wait_cnt_q != wait_max_lp) begin
                        wait_cnt_d    = wait_cnt_q + 1'b1;
                        irq_timeout_d = (wait_cnt_q == wait_last_lp);
                    end
                end
            end
            ST_IRQ_ISSUE: begin
                // Once launched the interrupt is never withdrawn.
                if (evt_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Issue slot: loads when empty or on the transfer edge, by priority
    always_comb begin
        evt_v_d     = evt_v_q;
        evt_type_d  = evt_type_q;
        evt_pc_d    = evt_pc_q;
        evt_vaddr_d = evt_vaddr_q;
        fault_take  = 1'b0;
        exc_take    = 1'b0;
        if (load_en) begin
            if (fault_v_q) begin
                evt_v_d     = 1'b1;
                evt_type_d  = evt_fault_lp;
                evt_pc_d    = fault_pc_q;
                evt_vaddr_d = fault_vaddr_q;
                fault_take  = 1'b1;
            end else if (exc_avail) begin
                evt_v_d     = 1'b1;
                evt_type_d  = evt_exc_lp;
                evt_pc_d    = exc_pc_q;
                evt_vaddr_d = '0;
                exc_take    = 1'b1;
            end else if (irq_launch) begin
                evt_v_d     = 1'b1;
                evt_type_d  = evt_irq_lp;
                evt_pc_d    = '0;
                evt_vaddr_d = '0;
            end else begin
                evt_v_d = 1'b0;
            end
        end
    end

    // Event buffers
    always_comb begin
        fault_v_d     = fault_v_q;
        fault_pc_d    = fault_pc_q;
        fault_vaddr_d = fault_vaddr_q;
        if (fault_in) begin
            fault_v_d     = 1'b1;
            fault_pc_d    = ptw_fault_pc_i;
            fault_vaddr_d = ptw_fault_vaddr_i;
        end else if (fault_take) begin
            fault_v_d = 1'b0;
        end

        // A new exception always lands, replacing any older one; a flush
        // only removes what was already buffered.
        exc_v_d  = exc_v_q;
        exc_pc_d = exc_pc_q;
        if (commit_exc_v_i) begin
            exc_v_d  = 1'b1;
            exc_pc_d = commit_pc_i;
        end else if (flush_i | exc_take) begin
            exc_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            idle_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            irq_timeout_q <= 1'b0;
            fault_v_q     <= 1'b0;
            fault_pc_q    <= '0;
            fault_vaddr_q <= '0;
            exc_v_q       <= 1'b0;
            exc_pc_q      <= '0;
            evt_v_q       <= 1'b0;
            evt_type_q    <= '0;
            evt_pc_q      <= '0;
            evt_vaddr_q   <= '0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            irq_timeout_q <= irq_timeout_d;
            fault_v_q     <= fault_v_d;
            fault_pc_q    <= fault_pc_d;
            fault_vaddr_q <= fault_vaddr_d;
            exc_v_q       <= exc_v_d;
            exc_pc_q      <= exc_pc_d;
            evt_v_q       <= evt_v_d;
            evt_type_q    <= evt_type_d;
            evt_pc_q      <= evt_pc_d;
            evt_vaddr_q   <= evt_vaddr_d;
        end
    end

`ifdef BP_SYS_EVT_PERF_EN
    logic [31:0] perf_irq_cnt_q, perf_irq_cnt_d;
    logic [31:0] perf_drain_cyc_q, perf_drain_cyc_d;

    // Both counters wrap naturally at 2^32.
    always_comb begin
        perf_irq_cnt_d   = perf_irq_cnt_q;
        perf_drain_cyc_d = perf_drain_cyc_q;
        if (evt_xfer && (evt_type_q == evt_irq_lp)) begin
            perf_irq_cnt_d = perf_irq_cnt_q + 32'd1;
        end
        if (state_q == ST_DRAIN) begin
            perf_drain_cyc_d = perf_drain_cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_irq_cnt_q   <= '0;
            perf_drain_cyc_q <= '0;
        end else begin
            perf_irq_cnt_q   <= perf_irq_cnt_d;
            perf_drain_cyc_q <= perf_drain_cyc_d;
        end
    end

    assign perf_irq_cnt_o   = perf_irq_cnt_q;
    assign perf_drain_cyc_o = perf_drain_cyc_q;
`endif

    assign ptw_fault_ready_o = ~fault_v_q;
    assign hold_dispatch_o   = (state_q != ST_IDLE);
    assign evt_v_o           = evt_v_q;
    assign evt_type_o        = evt_type_q;
    assign evt_pc_o          = evt_pc_q;
    assign evt_vaddr_o       = evt_vaddr_q;
    assign irq_timeout_o     = irq_timeout_q;

endmodule

// File: tb/tb_bp_be_sys_event_sched.sv
// ---------------------------------------------------------------------------
// tb_bp_be_sys_event_sched
//
// Directed bench for bp_be_sys_event_sched. A transaction-level model of the
// scheduler (pending fault / exception slots, one output slot, and an
// interrupt "drain run" tracked as consecutive quiet cycles and cycles spent
// waiting) predicts every output; a background process compares the DUT to
// it on each falling edge. Hand-computed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_bp_be_sys_event_sched;

    localparam int VW = 39;
    localparam int DC = 2;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ptw_fault_v = 1'b0;
    logic          ptw_fault_ready;
    logic [VW-1:0] ptw_fault_pc = '0;
    logic [VW-1:0] ptw_fault_vaddr = '0;
    logic          commit_exc_v = 1'b0;
    logic [VW-1:0] commit_pc = '0;
    logic          commit_v = 1'b0;
    logic          irq_pending = 1'b0;
    logic          mem_ready = 1'b1;
    logic          long_ready = 1'b1;
    logic          flush = 1'b0;
    logic          hold_dispatch;
    logic          evt_v;
    logic [1:0]    evt_type;
    logic [VW-1:0] evt_pc;
    logic [VW-1:0] evt_vaddr;
    logic          evt_ready = 1'b1;
    logic          irq_timeout;
`ifdef BP_SYS_EVT_PERF_EN
    logic [31:0]   perf_irq_cnt;
    logic [31:0]   perf_drain_cyc;
`endif

    always #5 clk = ~clk;

    bp_be_sys_event_sched #(
        .vaddr_width_p (VW),
        .drain_cycles_p(DC),
        .irq_timeout_p (TO)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (rst_n),
        .ptw_fault_v_i     (ptw_fault_v),
        .ptw_fault_ready_o (ptw_fault_ready),
        .ptw_fault_pc_i    (ptw_fault_pc),
        .ptw_fault_vaddr_i (ptw_fault_vaddr),
        .commit_exc_v_i    (commit_exc_v),
        .commit_pc_i       (commit_pc),
        .commit_v_i        (commit_v),
        .irq_pending_i     (irq_pending),
        .pipe_mem_ready_i  (mem_ready),
        .pipe_long_ready_i (long_ready),
        .flush_i           (flush),
        .hold_dispatch_o   (hold_dispatch),
        .evt_v_o           (evt_v),
        .evt_type_o        (evt_type),
        .evt_pc_o          (evt_pc),
        .evt_vaddr_o       (evt_vaddr),
        .evt_ready_i       (evt_ready),
        .irq_timeout_o     (irq_timeout)
`ifdef BP_SYS_EVT_PERF_EN
        ,
        .perf_irq_cnt_o    (perf_irq_cnt),
        .perf_drain_cyc_o  (perf_drain_cyc)
`endif
    );

    // ---------------- behavioural model ----------------
    // mode: 0 = no interrupt activity, 1 = draining, 2 = interrupt in slot
    typedef struct packed {
        logic          fh;
        logic [VW-1:0] fpc;
        logic [VW-1:0] fva;
        logic          eh;
        logic [VW-1:0] epc;
        logic          ov;
        logic [1:0]    ot;
        logic [VW-1:0] opc;
        logic [VW-1:0] ova;
        int            mode;
        int            run;
        int            age;
        logic          tmo;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(input mdl_t c,
                                  input logic fv, input logic [VW-1:0] fpc,
                                  input logic [VW-1:0] fva,
                                  input logic exc, input logic [VW-1:0] epc,
                                  input logic commit, input logic irq,
                                  input logic mem, input logic lng,
                                  input logic flsh, input logic rdy);
        mdl_t n;
        logic fault_in, slot_free, quiet, launch;
        n = c;
        n.tmo = 1'b0;
        launch = 1'b0;
        fault_in = fv && !c.fh;
        slot_free = !c.ov || rdy;
        quiet = mem && lng && !commit;
        if (c.mode == 0) begin
            if (irq && !c.fh && !c.eh && !c.ov) begin
                n.mode = 1;
                n.run = 0;
                n.age = 0;
            end
        end else if (c.mode == 1) begin
            if (!irq || flsh || fault_in || exc || c.fh || c.eh) begin
                n.mode = 0;
            end else if (quiet && (c.run + 1 >= DC)) begin
                n.mode = 2;
                launch = 1'b1;
            end else begin
                n.run = quiet ? c.run + 1 : 0;
                if (c.age < TO) begin
                    n.age = c.age + 1;
                    n.tmo = (n.age == TO);
                end
            end
        end else if (c.ov && rdy) begin
            n.mode = 0;
        end
        if (slot_free) begin
            if (c.fh) begin
                n.ov = 1'b1; n.ot = 2'd0; n.opc = c.fpc; n.ova = c.fva; n.fh = 1'b0;
            end else if (c.eh && !flsh) begin
                n.ov = 1'b1; n.ot = 2'd1; n.opc = c.epc; n.ova = '0; n.eh = 1'b0;
            end else if (launch) begin
                n.ov = 1'b1; n.ot = 2'd2; n.opc = '0; n.ova = '0;
            end else begin
                n.ov = 1'b0;
            end
        end
        if (fault_in) begin
            n.fh = 1'b1; n.fpc = fpc; n.fva = fva;
        end
        if (flsh) n.eh = 1'b0;
        if (exc) begin
            n.eh = 1'b1; n.epc = epc;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m, ptw_fault_v, ptw_fault_pc, ptw_fault_vaddr,
                       commit_exc_v, commit_pc, commit_v, irq_pending,
                       mem_ready, long_ready, flush, evt_ready);
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [127:0] act, exp;
        act = '0;
        exp = '0;
        act[83:80] = {ptw_fault_ready, hold_dispatch, evt_v, irq_timeout};
        exp[83:80] = {~m.fh, (m.mode != 0), m.ov, m.tmo};
        // Event payload only carries meaning while an event is offered.
        if (m.ov) begin
            act[79:0] = {evt_type, evt_pc, evt_vaddr};
            exp[79:0] = {m.ot, m.opc, m.ova};
        end
        chk("cycle_model", act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pulses;
    int pulse_at;
    int waited;
    logic found;

    initial begin
        tick();
        fork
            begin
                forever begin
                    @(negedge clk);
                    cmp_model();
                end
            end
        join_none
        tick();
        tick();
        // Reset state
        chk("rst_evt_v", evt_v, 0);
        chk("rst_fault_ready", ptw_fault_ready, 1);
        chk("rst_hold", hold_dispatch, 0);
        chk("rst_timeout", irq_timeout, 0);
        rst_n = 1'b1;
        tick();

        // Single fault
        ptw_fault_v = 1; ptw_fault_pc = 39'h100; ptw_fault_vaddr = 39'h2000;
        tick();
        ptw_fault_v = 0;
        chk("fault_buf_full_ready", ptw_fault_ready, 0);
        chk("fault_not_yet_issued", evt_v, 0);
        tick();
        chk("fault_evt_v", evt_v, 1);
        chk("fault_type", evt_type, 0);
        chk("fault_pc", evt_pc, 39'h100);
        chk("fault_vaddr", evt_vaddr, 39'h2000);
        chk("fault_ready_back", ptw_fault_ready, 1);
        tick();
        chk("fault_done", evt_v, 0);

        // Fault and exception in the same cycle
        ptw_fault_v = 1; ptw_fault_pc = 39'h104; ptw_fault_vaddr = 39'h3000;
        commit_exc_v = 1; commit_pc = 39'h108;
        tick();
        ptw_fault_v = 0; commit_exc_v = 0;
        tick();
        chk("both_first_type", evt_type, 0);
        chk("both_first_pc", evt_pc, 39'h104);
        tick();
        chk("both_second_v", evt_v, 1);
        chk("both_second_type", evt_type, 1);
        chk("both_second_pc", evt_pc, 39'h108);
        tick();
        chk("both_done", evt_v, 0);

        // Interrupt with idle pipes, CSR stalling
        irq_pending = 1; commit_v = 0; evt_ready = 0;
        tick();
        chk("irq_hold_c1", hold_dispatch, 1);
        chk("irq_no_evt_c1", evt_v, 0);
        tick();
        chk("irq_no_evt_c2", evt_v, 0);
        tick();
        chk("irq_evt_c3", evt_v, 1);
        chk("irq_type_c3", evt_type, 2);
        chk("irq_pc_zero", evt_pc, 0);
        irq_pending = 0;
        tick();
        chk("irq_not_withdrawn", evt_v, 1);
        chk("irq_hold_kept", hold_dispatch, 1);
        evt_ready = 1;
        tick();
        chk("irq_xfer_v", evt_v, 0);
        chk("irq_xfer_hold", hold_dispatch, 0);

        // Drain never completes: commit alternates, watchdog fires once
        irq_pending = 1; commit_v = 1;
        tick();
        pulses = 0; pulse_at = -1;
        for (int k = 0; k < 70; k++) begin
            commit_v = k[0];
            tick();
            if (irq_timeout === 1'b1) begin
                pulses++;
                pulse_at = k + 1;
            end
        end
        chk("timeout_pulse_count", pulses, 1);
        chk("timeout_pulse_cycle", pulse_at, TO);
        chk("timeout_still_drain", hold_dispatch, 1);
        chk("timeout_no_evt", evt_v, 0);
        irq_pending = 0; commit_v = 0;
        tick();
        chk("timeout_abort_hold", hold_dispatch, 0);

        // Exception aborts a drain; interrupt follows after a fresh drain
        irq_pending = 1; commit_v = 1;
        tick();
        chk("exc_abort_in_drain", hold_dispatch, 1);
        commit_exc_v = 1; commit_pc = 39'h200;
        tick();
        commit_exc_v = 0; commit_v = 0;
        chk("exc_abort_idle", hold_dispatch, 0);
        tick();
        chk("exc_abort_type", evt_type, 1);
        chk("exc_abort_pc", evt_pc, 39'h200);
        found = 0; waited = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (evt_v === 1'b1 && evt_type === 2'd2) begin
                found = 1;
                waited = i;
            end
        end
        chk("exc_then_irq_found", found, 1);
        chk("exc_then_irq_latency", waited, 4);
        irq_pending = 0;
        tick();
        chk("exc_then_irq_done", evt_v, 0);

        // Flush during drain
        irq_pending = 1; commit_v = 1;
        tick();
        flush = 1;
        tick();
        flush = 0; irq_pending = 0; commit_v = 0;
        chk("flush_abort_hold", hold_dispatch, 0);
        tick();

        // Stall with overwrite of the exception buffer
        evt_ready = 0;
        ptw_fault_v = 1; ptw_fault_pc = 39'h300; ptw_fault_vaddr = 39'h4000;
        tick();
        ptw_fault_v = 0;
        tick();
        commit_exc_v = 1; commit_pc = 39'h310;
        tick();
        commit_pc = 39'h320;
        tick();
        commit_exc_v = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc_stable", {evt_v, evt_type, evt_pc}, {1'b1, 2'd0, 39'h300});
        end
        evt_ready = 1;
        tick();
        evt_ready = 0;
        chk("overwrite_type", evt_type, 1);
        chk("overwrite_youngest", evt_pc, 39'h320);
        // Buffered exception removed by flush
        commit_exc_v = 1; commit_pc = 39'h400;
        tick();
        commit_exc_v = 0; flush = 1;
        tick();
        flush = 0; evt_ready = 1;
        tick();
        chk("flush_clears_exc", evt_v, 0);

        // Reset in the middle of a stall
        evt_ready = 0;
        ptw_fault_v = 1; ptw_fault_pc = 39'h500; ptw_fault_vaddr = 39'h5000;
        tick();
        ptw_fault_v = 0;
        tick();
        tick();
        chk("prereset_evt", evt_v, 1);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("async_rst_evt_v", evt_v, 0);
        chk("async_rst_pc", evt_pc, 0);
        chk("async_rst_hold", hold_dispatch, 0);
        chk("async_rst_fault_ready", ptw_fault_ready, 1);
        tick();
        tick();
        rst_n = 1;
        tick();
        tick();
        chk("post_rst_evt_v", evt_v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
